// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: I-port refill, D-port single beat and downstream burst.
interface mem_arbiter_if;
  logic        inst_read_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_read_data;
  logic        inst_valid;
  logic        inst_last;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_len;
  logic        mem_addr_ok;
  logic        mem_valid;
  logic        mem_last;
  logic [31:0] mem_rdata;
  logic        proto_err;

  modport slave (
    input  inst_read_req, inst_addr, data_req, data_we, data_addr, data_wdata,
           mem_addr_ok, mem_valid, mem_last, mem_rdata,
    output inst_addr_ok, inst_read_data, inst_valid, inst_last,
           data_addr_ok, data_rdata, data_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_len, proto_err
  );

  modport master (
    output inst_read_req, inst_addr, data_req, data_we, data_addr, data_wdata,
           mem_addr_ok, mem_valid, mem_last, mem_rdata,
    input  inst_addr_ok, inst_read_data, inst_valid, inst_last,
           data_addr_ok, data_rdata, data_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_len, proto_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: I-cache line refills and D-port single beats share one
// downstream burst interface with a single transaction in flight.
module mem_arbiter #(
  parameter int unsigned BURST_LEN = 16,
  parameter bit          DATA_PRIO = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, BEAT} state_t;
  typedef enum logic {PORT_INST, PORT_DATA} port_t;

  localparam logic [3:0] INST_LEN = 4'(BURST_LEN - 1);

  state_t      state, state_nxt;
  port_t       grant, last_grant, winner;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [3:0]  len_q, beat_cnt;
  logic        proto_err_q;
  logic        any_req, beat_end, bad_last, beat_fwd, idle_junk;

  assign any_req   = bus.inst_read_req | bus.data_req;
  assign beat_end  = (state == BEAT) & bus.mem_valid & bus.mem_last;
  assign bad_last  = beat_end & (beat_cnt != len_q);
  // A premature last beat still closes the burst but is never forwarded.
  assign beat_fwd  = (state == BEAT) & bus.mem_valid & ~bad_last;
  assign idle_junk = (state == IDLE) & (bus.mem_valid | bus.mem_addr_ok);

  always_comb begin
    winner = PORT_INST;
    if (bus.data_req && bus.inst_read_req) begin
      if (DATA_PRIO) winner = PORT_DATA;
      else           winner = (last_grant == PORT_INST) ? PORT_DATA : PORT_INST;
    end else if (bus.data_req) begin
      winner = PORT_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)         state_nxt = ADDR;
      ADDR:    if (bus.mem_addr_ok) state_nxt = BEAT;
      BEAT:    if (beat_end)        state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= PORT_INST;
      last_grant  <= PORT_INST;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      len_q       <= '0;
      beat_cnt    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        grant      <= winner;
        last_grant <= winner;
        if (winner == PORT_DATA) begin
          addr_q  <= bus.data_addr;
          wdata_q <= bus.data_wdata;
          we_q    <= bus.data_we;
          len_q   <= '0;
        end else begin
          addr_q  <= bus.inst_addr;
          wdata_q <= '0;
          we_q    <= 1'b0;
          len_q   <= INST_LEN;
        end
      end
      if (state == ADDR && bus.mem_addr_ok) beat_cnt <= '0;
      else if (state == BEAT && bus.mem_valid) beat_cnt <= beat_cnt + 4'd1;
      if (bad_last || idle_junk) proto_err_q <= 1'b1;
    end
  end

  always_comb begin
    bus.mem_req        = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    bus.mem_len        = '0;
    bus.inst_addr_ok   = 1'b0;
    bus.data_addr_ok   = 1'b0;
    bus.inst_valid     = 1'b0;
    bus.inst_last      = 1'b0;
    bus.inst_read_data = '0;
    bus.data_valid     = 1'b0;
    bus.data_rdata     = '0;
    bus.proto_err      = proto_err_q;
    if (state == ADDR) begin
      bus.mem_req      = 1'b1;
      bus.mem_we       = we_q;
      bus.mem_addr     = addr_q;
      bus.mem_wdata    = wdata_q;
      bus.mem_len      = len_q;
      bus.inst_addr_ok = bus.mem_addr_ok & (grant == PORT_INST);
      bus.data_addr_ok = bus.mem_addr_ok & (grant == PORT_DATA);
    end
    if (beat_fwd) begin
      if (grant == PORT_INST) begin
        bus.inst_valid     = 1'b1;
        bus.inst_read_data = bus.mem_rdata;
        bus.inst_last      = bus.mem_last;
      end else begin
        bus.data_valid = 1'b1;
        bus.data_rdata = we_q ? '0 : bus.mem_rdata;
      end
    end
  end
endmodule
